// File: rtl/ifetch_pkg.sv
// Shared fetch-unit definitions: widths, PC step, queue entry type.
// Imported by ifetch and ifetch_queue.
package ifetch_pkg;
  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEF = '0;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fq_entry_t;
endpackage

// File: rtl/ifetch_queue.sv
// Prefetch FIFO of fq_entry_t; the head always lives in slot 0.
// Flush drops all entries; the slots keep their last contents.
import ifetch_pkg::*;

module ifetch_queue #(
  parameter int DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             push,
  input  fq_entry_t                        wdata,
  input  logic                             pop,
  input  logic                             flush,
  output fq_entry_t                        head,
  output logic [$clog2(DEPTH+1)-1:0]       count,
  output logic                             empty,
  output logic                             full
);

  localparam int CW = $clog2(DEPTH+1);

  fq_entry_t         ent_q [DEPTH];
  fq_entry_t         ent_d [DEPTH];
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic              do_pop;
  logic              do_push;
  int                wr_idx;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign count = cnt_q;
  assign head  = ent_q[0];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign wr_idx  = int'(cnt_q) - (do_pop ? 1 : 0);

  always_comb begin
    ent_d = ent_q;
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else begin
      // Shift only live entries so a lone head keeps its value on pop.
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (do_pop && (i + 1 < int'(cnt_q)))
          ent_d[i] = ent_q[i+1];
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (do_push && (i == wr_idx))
          ent_d[i] = wdata;
      end
      unique case (1'b1)
        do_push && !do_pop: cnt_d = cnt_q + CW'(1);
        !do_push && do_pop: cnt_d = cnt_q - CW'(1);
        default:            cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        ent_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < DEPTH; i++)
        ent_q[i] <= ent_d[i];
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: fetch PC, prefetch queue, redirect flush.
// Optional fetch/redirect counters under IFETCH_PERF_CNT_EN.
import ifetch_pkg::*;

module ifetch #(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int              QDEPTH   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_en,
  output logic [XLEN-1:0]    iaddr,
  input  logic [INSTR_W-1:0] idata,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [INSTR_W-1:0] inst_data,
`ifdef IFETCH_PERF_CNT_EN
  output logic [31:0]        fetch_count,
  output logic [31:0]        redirect_count,
`endif
  output logic [XLEN-1:0]    inst_pc
);

  localparam int CW = $clog2(QDEPTH+1);

  logic [XLEN-1:0] fpc_q;
  logic [XLEN-1:0] fpc_d;
  logic            push;
  logic            pop;
  logic            q_empty;
  logic            q_full;
  logic [CW-1:0]   q_count_unused;
  fq_entry_t       q_head;
  fq_entry_t       q_wdata;

  assign iaddr      = fpc_q;
  assign inst_valid = !q_empty;
  assign pop        = inst_valid && inst_ready;
  assign push       = fetch_en && !redirect_valid && (!q_full || pop);
  assign inst_data  = q_head.instr;
  assign inst_pc    = q_head.pc;

  always_comb begin
    q_wdata       = '0;
    q_wdata.pc    = fpc_q;
    q_wdata.instr = idata;
  end

  always_comb begin
    fpc_d = fpc_q;
    if (redirect_valid)
      fpc_d = {redirect_pc[XLEN-1:2], 2'b00};
    else if (push)
      fpc_d = fpc_q + XLEN'(PC_STEP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fpc_q <= RESET_PC;
    else       fpc_q <= fpc_d;
  end

  ifetch_queue #(
    .DEPTH (QDEPTH)
  ) u_q (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (q_wdata),
    .pop   (pop),
    .flush (redirect_valid),
    .head  (q_head),
    .count (q_count_unused),
    .empty (q_empty),
    .full  (q_full)
  );

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fcnt_q;
  logic [31:0] fcnt_d;
  logic [31:0] rcnt_q;
  logic [31:0] rcnt_d;

  always_comb begin
    fcnt_d = fcnt_q + (pop ? 32'd1 : 32'd0);
    rcnt_d = rcnt_q + (redirect_valid ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fcnt_q <= '0;
      rcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
      rcnt_q <= rcnt_d;
    end
  end

  assign fetch_count    = fcnt_q;
  assign redirect_count = rcnt_q;
`endif

endmodule

// File: tb/tb_ifetch.sv
// Scoreboard bench for ifetch: expected PCs queued at stimulus,
// checked against inst_pc/inst_data on every accepted handshake.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic [31:0] iaddr;
  logic [31:0] idata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] redirect_count;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int n_acc  = 0;
  int a0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mword(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  assign idata = mword(iaddr);

  ifetch dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .iaddr          (iaddr),
    .idata          (idata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
`ifdef IFETCH_PERF_CNT_EN
    .fetch_count    (fetch_count),
    .redirect_count (redirect_count),
`endif
    .inst_pc        (inst_pc)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic exp_seq(input logic [31:0] base);
    exp_q.delete();
    for (int k = 0; k < 24; k++)
      exp_q.push_back(base + 32'(4 * k));
  endtask

  task automatic tick();
    logic [31:0] e;
    #1;
    if (inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pc", inst_pc, e);
        check("data", inst_data, mword(e));
        n_acc++;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset          = 1'b1;
    fetch_en       = 1'b1;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #1;
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_iaddr", iaddr, 32'h0);
    check("rst_data", inst_data, 32'h0);
    check("rst_pc", inst_pc, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_seq(32'h0);
  endtask

  initial begin
    reset          = 1'b1;
    fetch_en       = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // reset and stream
    do_reset();
    inst_ready = 1'b1;
    #1 check("lat0_valid", 32'(inst_valid), 32'd0);
    tick();
    #1 check("lat1_valid", 32'(inst_valid), 32'd1);
    a0 = n_acc;
    repeat (6) tick();
    check("stream_thru", 32'(n_acc - a0), 32'd6);

    // back-pressure
    do_reset();
    repeat (5) tick();
    #1;
    check("bp_count", 32'(dut.u_q.cnt_q), 32'd2);
    check("bp_iaddr", iaddr, 32'h8);
    check("bp_head", inst_pc, 32'h0);
    inst_ready = 1'b1;
    a0 = n_acc;
    repeat (4) tick();
    check("bp_thru", 32'(n_acc - a0), 32'd4);

    // redirect while full
    inst_ready = 1'b0;
    repeat (3) tick();
    check("rd_full", 32'(dut.u_q.cnt_q), 32'd2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h43;
    tick();
    exp_seq(32'h40);
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    #1 check("rd_bubble", 32'(inst_valid), 32'd0);
    tick();
    #1;
    check("rd_valid", 32'(inst_valid), 32'd1);
    check("rd_mem16", inst_data, 32'h1000_0010);
    a0 = n_acc;
    repeat (3) tick();
    check("rd_thru", 32'(n_acc - a0), 32'd3);

    // redirect with simultaneous pop
    a0 = n_acc;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    check("rp_pop_once", 32'(n_acc - a0), 32'd1);
    exp_seq(32'h100);
    redirect_valid = 1'b0;
    #1 check("rp_bubble", 32'(inst_valid), 32'd0);
    a0 = n_acc;
    repeat (3) tick();
    check("rp_thru", 32'(n_acc - a0), 32'd2);

    // wrap and fetch_en
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    exp_seq(32'hFFFF_FFFC);
    redirect_valid = 1'b0;
    tick();
    #1 check("wr_head", inst_pc, 32'hFFFF_FFFC);
    tick();
    #1 check("wr_zero", inst_pc, 32'h0);
    tick();
    fetch_en = 1'b0;
    tick();
    #1;
    check("fe_drain", 32'(inst_valid), 32'd0);
    check("fe_iaddr", iaddr, 32'h8);
    repeat (2) tick();
    #1;
    check("fe_hold", iaddr, 32'h8);
    check("fe_empty", 32'(inst_valid), 32'd0);

    // async reset mid-stream
    fetch_en = 1'b1;
    repeat (3) tick();
    #1 check("ar_pre", 32'(inst_valid), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("ar_valid", 32'(inst_valid), 32'd0);
    check("ar_iaddr", iaddr, 32'h0);
`ifdef IFETCH_PERF_CNT_EN
    check("ar_fcnt", fetch_count, 32'd0);
    check("ar_rcnt", redirect_count, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    exp_seq(32'h0);
    a0 = n_acc;
    repeat (4) tick();
    check("ar_thru", 32'(n_acc - a0), 32'd3);
`ifdef IFETCH_PERF_CNT_EN
    #1 check("pc_fcnt3", fetch_count, 32'd3);
    inst_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("pc_rcnt1", redirect_count, 32'd1);
    check("pc_fcnt_hold", fetch_count, 32'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
